// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-function decode path.
// Contents:
//   - ALU function codes ADD..NOP (3 bits, zero-extended by users of wider codes)
//   - R-type funct constants F_ADD..F_NOP
//   - main-control selector modes SEL_*
//   - sequencer state enum {IDLE, RUN}
package alu_pkg;

    // ALU function codes
    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] AND  = 3'b010;
    localparam logic [2:0] OR   = 3'b011;
    localparam logic [2:0] SLT  = 3'b100;
    localparam logic [2:0] MULT = 3'b101;
    localparam logic [2:0] DIV  = 3'b110;
    localparam logic [2:0] NOP  = 3'b111;

    // R-type funct field values
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_NOP  = 6'b000000;

    // Main-control selector modes; 110/111 are undefined
    localparam logic [2:0] SEL_RTYPE = 3'b000;
    localparam logic [2:0] SEL_ADD   = 3'b001;
    localparam logic [2:0] SEL_SUB   = 3'b010;
    localparam logic [2:0] SEL_AND   = 3'b011;
    localparam logic [2:0] SEL_OR    = 3'b100;
    localparam logic [2:0] SEL_SLT   = 3'b101;

    // Sequencer states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_control_seq_if.sv
// Handshake/bus bundle between the execute-stage issuer and alu_control_seq.
// Signals:
//   in_valid  : sel/func valid this cycle (issuer -> block)
//   in_ready  : block can accept (block -> issuer)
//   sel, func : main-control mode and R-type funct field
//   alu_f     : registered ALU function code
//   busy      : multi-cycle op in progress
//   done      : one-cycle completion pulse for the op in alu_f
//   illegal   : qualifies done; the decoded op was undefined
// Modports: master = issuer side, slave = alu_control_seq side.
interface alu_control_seq_if #(
    parameter int FUNC_W = 6,
    parameter int SEL_W  = 3,
    parameter int ALUF_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  sel;
    logic [FUNC_W-1:0] func;
    logic [ALUF_W-1:0] alu_f;
    logic              busy;
    logic              done;
    logic              illegal;

    modport master (
        output in_valid, sel, func,
        input  in_ready, alu_f, busy, done, illegal
    );

    modport slave (
        input  in_valid, sel, func,
        output in_ready, alu_f, busy, done, illegal
    );
endinterface

// File: rtl/alu_func_decode.sv
// Purely combinational ALU-function decoder (sel, func -> code, illegal,
// is_multi). Shared with the hazard unit, so it carries no state.
// Ports:
//   sel      in  SEL_W   main-control mode
//   func     in  FUNC_W  funct field (only used when sel selects R-type)
//   code     out ALUF_W  ALU function code, zero-extended from 3 bits
//   illegal  out 1       undefined sel or funct; code is NOP
//   is_multi out 1       op belongs to the multi-cycle class (MULT/DIV)
module alu_func_decode
    import alu_pkg::*;
#(
    parameter int FUNC_W = 6,
    parameter int SEL_W  = 3,
    parameter int ALUF_W = 3
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic [FUNC_W-1:0] func,
    output logic [ALUF_W-1:0] code,
    output logic              illegal,
    output logic              is_multi
);

    logic [2:0] op;

    always_comb begin
        op       = NOP;
        illegal  = 1'b0;
        is_multi = 1'b0;
        case (sel)
            SEL_W'(SEL_RTYPE): begin
                case (func)
                    FUNC_W'(F_ADD):  op = ADD;
                    FUNC_W'(F_SUB):  op = SUB;
                    FUNC_W'(F_AND):  op = AND;
                    FUNC_W'(F_OR):   op = OR;
                    FUNC_W'(F_SLT):  op = SLT;
                    FUNC_W'(F_MULT): begin
                        op       = MULT;
                        is_multi = 1'b1;
                    end
                    FUNC_W'(F_DIV): begin
                        op       = DIV;
                        is_multi = 1'b1;
                    end
                    FUNC_W'(F_NOP):  op = NOP;
                    default:         illegal = 1'b1;
                endcase
            end
            SEL_W'(SEL_ADD): op = ADD;
            SEL_W'(SEL_SUB): op = SUB;
            SEL_W'(SEL_AND): op = AND;
            SEL_W'(SEL_OR):  op = OR;
            SEL_W'(SEL_SLT): op = SLT;
            default:         illegal = 1'b1;
        endcase
    end

    assign code = ALUF_W'(op);

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU-function decoder with valid/ready handshake and a
// multi-cycle sequencer for MULT/DIV. While a long op runs, alu_f is held,
// busy is high and in_ready drops until the final cycle, where done pulses
// and a new op may be accepted with no bubble.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; aborts a running op without done
//   bus  : alu_control_seq_if.slave (in_valid/in_ready, sel, func,
//          alu_f, busy, done, illegal)
module alu_control_seq
    import alu_pkg::*;
#(
    parameter int FUNC_W     = 6,
    parameter int SEL_W      = 3,
    parameter int ALUF_W     = 3,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst,
    alu_control_seq_if.slave bus
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [ALUF_W-1:0] dec_code;
    logic              dec_illegal;
    logic              dec_multi;

    state_e            state_reg,   state_next;
    logic [CNT_W-1:0]  count_reg,   count_next;
    logic [ALUF_W-1:0] alu_f_reg,   alu_f_next;
    logic              illegal_reg, illegal_next;
    logic              done_reg,    done_next;

    logic              in_ready_int;
    logic              accept;
    logic [CNT_W-1:0]  lat_m1;
    logic              long_op;

    alu_func_decode #(
        .FUNC_W (FUNC_W),
        .SEL_W  (SEL_W),
        .ALUF_W (ALUF_W)
    ) u_decode (
        .sel      (bus.sel),
        .func     (bus.func),
        .code     (dec_code),
        .illegal  (dec_illegal),
        .is_multi (dec_multi)
    );

    // Remaining-cycle count to load on accept. A latency of 1 degenerates
    // to a single-cycle op, so such an op never enters RUN.
    always_comb begin
        lat_m1 = '0;
        if (dec_multi && dec_code == ALUF_W'(MULT)) begin
            lat_m1 = CNT_W'(MUL_CYCLES - 1);
        end else if (dec_multi && dec_code == ALUF_W'(DIV)) begin
            lat_m1 = CNT_W'(DIV_CYCLES - 1);
        end
    end

    assign long_op = (lat_m1 != '0);

    // Ready in IDLE and in the last RUN cycle (counter exhausted).
    assign in_ready_int = (state_reg == IDLE) || (count_reg == '0);
    assign accept       = bus.in_valid && in_ready_int;

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        alu_f_next   = alu_f_reg;
        illegal_next = illegal_reg;
        done_next    = 1'b0;

        if (state_reg == RUN) begin
            if (count_reg != '0) begin
                count_next = count_reg - 1'b1;
            end else begin
                state_next = IDLE;
            end
        end

        if (accept) begin
            alu_f_next   = dec_code;
            illegal_next = dec_illegal;
            if (long_op) begin
                state_next = RUN;
                count_next = lat_m1;
            end else begin
                state_next = IDLE;
                count_next = '0;
                done_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            alu_f_reg   <= ALUF_W'(NOP);
            illegal_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            alu_f_reg   <= alu_f_next;
            illegal_reg <= illegal_next;
            done_reg    <= done_next;
        end
    end

    assign bus.in_ready = in_ready_int;
    assign bus.alu_f    = alu_f_reg;
    assign bus.illegal  = illegal_reg;
    assign bus.busy     = (state_reg == RUN);
    // Single-cycle ops complete via done_reg; long ops complete in the RUN
    // cycle where the counter reaches zero. The two never coincide.
    assign bus.done     = done_reg || ((state_reg == RUN) && (count_reg == '0));

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Parametrised, registered successor to the combinational ALU-function decoder in the execute stage.
- Decodes the main-control selector (sel) and the R-type funct field into the ALU function code.
- Adds I-type modes, an illegal-instruction flag and a valid/ready handshake.
- Sequences multi-cycle MULT/DIV: holds the code stable, deasserts ready and pulses done on completion so the pipeline can stall.

Parameters:
- FUNC_W, 6, funct field width.
- SEL_W, 3, main-control selector width.
- ALUF_W, 3, ALU function code width (>=3; codes zero-extended).
- MUL_CYCLES, 4, MULT latency in cycles (>=1).
- DIV_CYCLES, 8, DIV latency in cycles (>=1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sel/func valid this cycle.
- in_ready  out  1  block can accept; transfer when in_valid & in_ready at a rising edge.
- sel  in  SEL_W  main-control ALU mode.
- func  in  FUNC_W  instruction funct field.
- alu_f  out  ALUF_W  registered ALU function code.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse; op in alu_f completes this cycle.
- illegal  out  1  qualifies done; decoded op was undefined.

Behaviour:
- Codes: ADD=000, SUB=001, AND=010, OR=011, SLT=100, MULT=101, DIV=110, NOP=111.
- sel=000, R-type. func decodes as:
  - 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 101010 SLT.
  - 011000 MULT; 011010 DIV; 000000 NOP.
  - Any other func: NOP with illegal=1.
- sel=001 ADD; 010 SUB; 011 AND; 100 OR; 101 SLT. func ignored.
- sel=110/111: NOP with illegal=1.
- Decode is fully specified; no latches, no held-over values.
- Reset values: alu_f=NOP, busy=0, done=0, illegal=0, in_ready=1, state=IDLE, counter=0.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0 except in the final cycle.
- Accept at edge k:
  - alu_f and illegal load the decoded values, visible from cycle k+1.
  - L = MUL_CYCLES for MULT, DIV_CYCLES for DIV, 1 otherwise.
- L=1: done=1 in cycle k+1; state stays IDLE; in_ready stays 1. Back-to-back accepts give one done per cycle.
- L>1: state goes to RUN; counter loads L-1.
  - Cycles k+1..k+L: busy=1.
  - Cycles k+1..k+L-1: in_ready=0.
  - Cycle k+L (counter==0): done=1, in_ready=1.
  - A new accept at that edge is legal: it returns to IDLE or re-enters RUN with zero bubble.
- No accept: done=0; alu_f and illegal hold their last values.
- Inputs while in_ready=0 are ignored. Upstream must hold them; the block does not buffer.
- rst mid-RUN: aborts at the next edge. No done pulse for the aborted op; all outputs return to reset values.
- Counter width: $clog2(max(MUL_CYCLES, DIV_CYCLES)+1); no wrap.
- MUL_CYCLES=1 (or DIV_CYCLES=1): that op behaves as a single-cycle op; busy never asserts for it.

Decomposition:
- Shared package alu_pkg:
  - ALU code localparams ADD..NOP.
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MULT, F_DIV, F_NOP.
  - sel mode constants and the state enum {IDLE, RUN}.
- One natural sub-module: alu_func_decode. It is purely combinational (sel, func -> code, illegal, is_multi) and reusable by the hazard unit.
- alu_control_seq holds the registers, the counter and the FSM.

Test Plan:
- Reset, then sel=000 func=100010 for one cycle -> cycle k+1: alu_f=001, done=1, illegal=0, busy=0.
- Back-to-back ADD, OR, SLT (funcs 100000, 100101, 101010) -> alu_f=000, 011, 100 on consecutive cycles; done high for 3 cycles; in_ready always 1.
- MULT (func 011000), MUL_CYCLES=4 -> alu_f=101 and busy=1 for cycles k+1..k+4; in_ready=0 for k+1..k+3; done=1 only at k+4. A SUB accepted at k+4 gives done at k+5.
- DIV (011010), DIV_CYCLES=8, rst asserted at cycle k+3 -> cycle k+4: alu_f=111, busy=0, in_ready=1; no done pulse at any point.
- Illegal inputs: sel=000 func=111111, then sel=111 -> both give alu_f=111 with done=1 and illegal=1; the following legal sel=001 clears illegal (alu_f=000).
- Parameter sweep MUL_CYCLES=1, DIV_CYCLES=2 -> MULT completes next cycle with busy=0; DIV shows busy for 2 cycles with done at k+2.
